ihp13_sram_bist_ctrl: RTL and testbench

- March C- memory BIST initiator for one IHP SG13 single-port SRAM cut (RM_IHPSG13_1P_*_bm_bist).
- Drives the cut's A_BIST_* port group and checks read data from A_DOUT.
- Sits beside each hard-macro instance inside the tc_sram target wrapper and takes over the cut while A_BIST_EN is high.
- Reports pass/fail, the first failing address and a saturating fail count to a status register block.

---
 rtl/ihp13_bist_pkg.sv | 78 +++++++
 rtl/ihp13_bist_addr_gen.sv | 52 +++++
 rtl/ihp13_sram_bist_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_ihp13_sram_bist_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ihp13_bist_pkg.sv
// Shared types and the March C- element table for the SRAM BIST controller.
//   march_elem_e : controller state / current march element
//   op_e         : operation issued to the cut in a given cycle
//   ElemTbl      : per-element sweep direction, read/write polarity, two-op flag
package ihp13_bist_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    M0    = 4'd1,
    M1    = 4'd2,
    M2    = 4'd3,
    M3    = 4'd4,
    M4    = 4'd5,
    M5    = 4'd6,
    DRAIN = 4'd7,
    DONE  = 4'd8
  } march_elem_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // down: sweep high->low; rd_inv/wr_inv: compare/write ~B instead of B;
  // two_op: read then write at each address.
  typedef struct packed {
    logic down;
    logic rd_inv;
    logic wr_inv;
    logic two_op;
  } elem_cfg_t;

  localparam elem_cfg_t ElemTbl [16] = '{
    elem_cfg_t'(4'b0000),  // IDLE
    elem_cfg_t'(4'b0000),  // M0 up   w(B)
    elem_cfg_t'(4'b0011),  // M1 up   r(B)  w(~B)
    elem_cfg_t'(4'b0101),  // M2 up   r(~B) w(B)
    elem_cfg_t'(4'b1011),  // M3 down r(B)  w(~B)
    elem_cfg_t'(4'b1101),  // M4 down r(~B) w(B)
    elem_cfg_t'(4'b1000),  // M5 down r(B)
    elem_cfg_t'(4'b0000),  // DRAIN
    elem_cfg_t'(4'b0000),  // DONE
    elem_cfg_t'(4'b0000),
    elem_cfg_t'(4'b0000),
    elem_cfg_t'(4'b0000),
    elem_cfg_t'(4'b0000),
    elem_cfg_t'(4'b0000),
    elem_cfg_t'(4'b0000),
    elem_cfg_t'(4'b0000)
  };

  // True for the states that access the cut.
  function automatic logic elem_active(input march_elem_e e);
    case (e)
      M0, M1, M2, M3, M4, M5: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Operation issued in element e; two-op elements read in phase 0, write in phase 1.
  function automatic op_e elem_op(input march_elem_e e, input logic phase);
    if (ElemTbl[e].two_op) return phase ? OP_WR : OP_RD;
    return (e == M0) ? OP_WR : OP_RD;
  endfunction

  // Element following e within one pass; M5 is resolved by the controller.
  function automatic march_elem_e elem_next(input march_elem_e e);
    case (e)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      M4:      return M5;
      default: return DRAIN;
    endcase
  endfunction

endpackage

// File: rtl/ihp13_bist_addr_gen.sv
// Up/down address counter for the march sweeps.
//   load_i/load_down_i : restart at 0 (up) or NumWords-1 (down), latching direction
//   step_i             : advance one address in the latched direction
//   addr_o             : current address (registered)
//   addr_nxt_c         : address after this edge (combinational)
//   last_c             : current address is the final one of the sweep
module ihp13_bist_addr_gen #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 load_down_i,
  input  logic                 step_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic [AddrWidth-1:0] addr_nxt_c,
  output logic                 last_c
);

  localparam logic [AddrWidth-1:0] AddrMax = AddrWidth'(NumWords - 1);

  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 dir_q, dir_d;

  // Next address / direction.
  always_comb begin
    addr_d = addr_q;
    dir_d  = dir_q;
    if (load_i) begin
      dir_d  = load_down_i;
      addr_d = load_down_i ? AddrMax : '0;
    end else if (step_i) begin
      addr_d = dir_q ? addr_q - AddrWidth'(1) : addr_q + AddrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      dir_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      dir_q  <= dir_d;
    end
  end

  assign addr_o     = addr_q;
  assign addr_nxt_c = addr_d;
  assign last_c     = dir_q ? (addr_q == '0) : (addr_q == AddrMax);

endmodule

// File: rtl/ihp13_sram_bist_ctrl.sv
// March C- BIST initiator for one IHP SG13 single-port SRAM cut.
// Drives the cut's A_BIST_* group, compares A_DOUT one cycle after each read,
// and reports pass/fail, first failing address and a saturating fail count.
// Ports: clk_i/rst_ni; start_i; busy_o/done_o/pass_o/fail_addr_o/fail_cnt_o
// status; bist_{en,men,wen,ren,addr,din,bm}_o to the cut; bist_dout_i from it.
// Optional: IHP13_BIST_CHECKERBOARD_EN adds a second pass with a checkerboard
// background (alternating bits, inverted on odd addresses).
module ihp13_sram_bist_ctrl
  import ihp13_bist_pkg::*;
#(
  parameter int unsigned NumWords     = 256,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned FailCntWidth = 16,
  parameter int unsigned AddrWidth    = $clog2(NumWords)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [AddrWidth-1:0]    fail_addr_o,
  output logic [FailCntWidth-1:0] fail_cnt_o,
  output logic                    bist_en_o,
  output logic                    bist_men_o,
  output logic                    bist_wen_o,
  output logic                    bist_ren_o,
  output logic [AddrWidth-1:0]    bist_addr_o,
  output logic [DataWidth-1:0]    bist_din_o,
  output logic [DataWidth-1:0]    bist_bm_o,
  input  logic [DataWidth-1:0]    bist_dout_i
);

`ifdef IHP13_BIST_CHECKERBOARD_EN
  localparam bit CbEn = 1'b1;
`else
  localparam bit CbEn = 1'b0;
`endif

  // Background for address a: zeros in pass 1, checkerboard in pass 2.
  function automatic logic [DataWidth-1:0] pattern(input logic [AddrWidth-1:0] a,
                                                   input logic inv, input logic p2);
    logic [DataWidth-1:0] alt, base;
    for (int unsigned i = 0; i < DataWidth; i++) alt[i] = i[0];
    base = p2 ? (a[0] ? alt : ~alt) : '0;
    return inv ? ~base : base;
  endfunction

  march_elem_e             state_q, state_d;
  logic                    phase_q, phase_d;
  logic                    pass2_q, pass2_d;
  logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [FailCntWidth-1:0] fail_cnt_q, fail_cnt_d;
  logic [AddrWidth-1:0]    fail_addr_q, fail_addr_d;
  logic                    en_q, en_d, men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic [DataWidth-1:0]    din_q, din_d, bm_q, bm_d;
  logic                    cmp_valid_q, cmp_valid_d;
  logic [DataWidth-1:0]    exp_q, exp_d;
  logic [AddrWidth-1:0]    cmp_addr_q, cmp_addr_d;

  logic                    load, load_down, step, adv, active;
  op_e                     op;
  logic [AddrWidth-1:0]    addr, addr_nxt_c;
  logic                    last_c;

  ihp13_bist_addr_gen #(
    .NumWords  (NumWords),
    .AddrWidth (AddrWidth)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (load),
    .load_down_i (load_down),
    .step_i      (step),
    .addr_o      (addr),
    .addr_nxt_c  (addr_nxt_c),
    .last_c      (last_c)
  );

  // Next state, compare bookkeeping and next cut-port values.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pass2_d     = pass2_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_cnt_d  = fail_cnt_q;
    fail_addr_d = fail_addr_q;
    load        = 1'b0;
    load_down   = 1'b0;
    step        = 1'b0;
    adv         = 1'b0;

    // Data for the read issued last cycle is on bist_dout_i now.
    if (cmp_valid_q && (bist_dout_i != exp_q)) begin
      if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + FailCntWidth'(1);
      if (fail_cnt_q == '0) fail_addr_d = cmp_addr_q;
    end
    cmp_valid_d = ren_q;
    exp_d       = pattern(addr, ElemTbl[state_q].rd_inv, pass2_q);
    cmp_addr_d  = addr;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = M0;
          phase_d     = 1'b0;
          pass2_d     = 1'b0;
          load        = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_cnt_d  = '0;
          fail_addr_d = '0;
        end
      end
      M0, M1, M2, M3, M4, M5: begin
        adv = !ElemTbl[state_q].two_op || phase_q;
        if (!adv) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!last_c) begin
            step = 1'b1;
          end else if (state_q == M5) begin
            if (CbEn && !pass2_q) begin
              state_d = M0;
              pass2_d = 1'b1;
              load    = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            state_d   = elem_next(state_q);
            load      = 1'b1;
            load_down = ElemTbl[state_d].down;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (fail_cnt_d == '0);
      end
      default: state_d = IDLE;
    endcase

    active = elem_active(state_d);
    op     = elem_op(state_d, phase_d);
    en_d   = active || (state_d == DRAIN);
    men_d  = active;
    wen_d  = active && (op == OP_WR);
    ren_d  = active && (op == OP_RD);
    din_d  = wen_d ? pattern(addr_nxt_c, ElemTbl[state_d].wr_inv, pass2_d) : '0;
    bm_d   = busy_d ? '1 : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      pass2_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_cnt_q  <= '0;
      fail_addr_q <= '0;
      en_q        <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      din_q       <= '0;
      bm_q        <= '0;
      cmp_valid_q <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pass2_q     <= pass2_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_addr_q <= fail_addr_d;
      en_q        <= en_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
      cmp_valid_q <= cmp_valid_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_cnt_o  = fail_cnt_q;
  assign bist_en_o   = en_q;
  assign bist_men_o  = men_q;
  assign bist_wen_o  = wen_q;
  assign bist_ren_o  = ren_q;
  assign bist_addr_o = addr;
  assign bist_din_o  = din_q;
  assign bist_bm_o   = bm_q;

endmodule

// File: tb/tb_ihp13_sram_bist_ctrl.sv
// Directed bench for ihp13_sram_bist_ctrl with a behavioural 1-cycle-read SRAM
// cut that can inject a stuck-at-1 or a coupling fault.
module tb_ihp13_sram_bist_ctrl;

  localparam int unsigned NumWords     = 256;
  localparam int unsigned DataWidth    = 64;
  localparam int unsigned FailCntWidth = 16;
  localparam int unsigned AddrWidth    = 8;
`ifdef IHP13_BIST_CHECKERBOARD_EN
  localparam int Passes   = 2;
  localparam int SaFails  = 6;
`else
  localparam int Passes   = 1;
  localparam int SaFails  = 3;
`endif
  localparam int DoneEdge  = 10 * NumWords * Passes + 1;
  localparam int DrainEdge = DoneEdge - 1;
  localparam int ReadCnt   = 5 * NumWords * Passes;

  logic                    clk, rst_n, start_i;
  logic                    busy_o, done_o, pass_o;
  logic [AddrWidth-1:0]    fail_addr_o;
  logic [FailCntWidth-1:0] fail_cnt_o;
  logic                    bist_en_o, bist_men_o, bist_wen_o, bist_ren_o;
  logic [AddrWidth-1:0]    bist_addr_o;
  logic [DataWidth-1:0]    bist_din_o, bist_bm_o, bist_dout_i;

  logic [DataWidth-1:0]    mem [NumWords];
  logic [DataWidth-1:0]    rd_word;
  int                      fault_mode;
  int                      n_checks, n_pass;

  ihp13_sram_bist_ctrl #(
    .NumWords     (NumWords),
    .DataWidth    (DataWidth),
    .FailCntWidth (FailCntWidth)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .fail_addr_o (fail_addr_o),
    .fail_cnt_o  (fail_cnt_o),
    .bist_en_o   (bist_en_o),
    .bist_men_o  (bist_men_o),
    .bist_wen_o  (bist_wen_o),
    .bist_ren_o  (bist_ren_o),
    .bist_addr_o (bist_addr_o),
    .bist_din_o  (bist_din_o),
    .bist_bm_o   (bist_bm_o),
    .bist_dout_i (bist_dout_i)
  );

  always #5 clk = ~clk;

  // Cut model: synchronous write, read data valid the cycle after the read.
  // fault 1: bit 3 of 0x12 reads as 1; fault 2: writing bit0=1 to 0x40 flips 0x41 bit 0.
  always @(posedge clk) begin
    if (bist_en_o && bist_men_o) begin
      if (bist_ren_o) begin
        rd_word = mem[bist_addr_o];
        if (fault_mode == 1 && bist_addr_o == 8'h12) rd_word[3] = 1'b1;
        bist_dout_i <= rd_word;
      end
      if (bist_wen_o) begin
        mem[bist_addr_o] = bist_din_o;
        if (fault_mode == 2 && bist_addr_o == 8'h40 && bist_din_o[0])
          mem[8'h41][0] = ~mem[8'h41][0];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Start a run, check boundary cycles, wait (bounded) for done_o.
  task automatic run_bist(input bit hold, input string tag);
    int done_edge;
    int rd_cnt;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_i = 1'b0;
    check({tag, "_e0_busy"}, busy_o, 1);
    check({tag, "_e0_done"}, done_o, 0);
    check({tag, "_e0_failcnt"}, fail_cnt_o, 0);
    check({tag, "_e0_failaddr"}, fail_addr_o, 0);
    check({tag, "_e0_wen"}, {bist_en_o, bist_men_o, bist_wen_o, bist_ren_o}, 4'b1110);
    check({tag, "_e0_addr"}, bist_addr_o, 0);
    check({tag, "_e0_din"}, bist_din_o, 0);
    check({tag, "_e0_bm"}, bist_bm_o, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_cnt    = 0;
    done_edge = -1;
    for (int k = 1; k <= DoneEdge + 50; k++) begin
      @(posedge clk); #1;
      if (bist_ren_o) rd_cnt++;
      if (k == NumWords - 1) check({tag, "_m0_last"}, {bist_wen_o, bist_addr_o}, {1'b1, 8'hFF});
      if (k == NumWords) check({tag, "_m1_first"}, {bist_ren_o, bist_addr_o}, {1'b1, 8'h00});
      if (k == NumWords + 1) check({tag, "_m1_wr"}, bist_din_o, 64'hFFFF_FFFF_FFFF_FFFF);
      if (k == 5 * NumWords) check({tag, "_m3_first"}, {bist_ren_o, bist_addr_o}, {1'b1, 8'hFF});
      if (k == DrainEdge) check({tag, "_drain"}, {bist_en_o, bist_men_o, busy_o}, 3'b101);
`ifdef IHP13_BIST_CHECKERBOARD_EN
      if (k == 10 * NumWords + 1)
        check({tag, "_cb_din"}, {bist_wen_o, bist_addr_o}, {1'b1, 8'h01});
      if (k == 10 * NumWords + 1)
        check({tag, "_cb_pat"}, bist_din_o, 64'hAAAA_AAAA_AAAA_AAAA);
`endif
      if (done_o) begin
        done_edge = k;
        break;
      end
    end
    start_i = 1'b0;
    check({tag, "_done_edge"}, done_edge, DoneEdge);
    check({tag, "_reads"}, rd_cnt, ReadCnt);
    check({tag, "_idle_ports"}, {busy_o, bist_en_o, bist_men_o}, 3'b000);
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b1;
    start_i    = 1'b0;
    fault_mode = 0;
    n_checks   = 0;
    n_pass     = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_status", {busy_o, done_o, pass_o}, 3'b000);
    check("rst_failaddr", fail_addr_o, 0);
    check("rst_failcnt", fail_cnt_o, 0);
    check("rst_ctrl", {bist_en_o, bist_men_o, bist_wen_o, bist_ren_o}, 4'b0000);
    check("rst_addr", bist_addr_o, 0);
    check("rst_din", bist_din_o, 0);
    check("rst_bm", bist_bm_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_bist(1'b0, "clean");
    check("clean_pass", pass_o, 1);
    check("clean_failcnt", fail_cnt_o, 0);

    fault_mode = 1;
    run_bist(1'b0, "sa1");
    check("sa1_pass", pass_o, 0);
    check("sa1_failaddr", fail_addr_o, 8'h12);
    check("sa1_failcnt", fail_cnt_o, SaFails);

    // Restart from DONE with start held for the whole run.
    fault_mode = 0;
    run_bist(1'b1, "held");
    check("held_pass", pass_o, 1);
    repeat (5) @(posedge clk);
    #1;
    check("held_done_stays", {done_o, busy_o, pass_o}, 3'b101);

    fault_mode = 2;
    run_bist(1'b0, "cpl");
    check("cpl_pass", pass_o, 0);
    check("cpl_failaddr", fail_addr_o, 8'h41);
`ifndef IHP13_BIST_CHECKERBOARD_EN
    check("cpl_failcnt", fail_cnt_o, 2);
`endif

    // Reset in the middle of a run.
    fault_mode = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (700) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_en", {bist_en_o, bist_men_o, bist_wen_o, bist_ren_o}, 4'b0000);
    check("midrst_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_status", {busy_o, done_o, pass_o, bist_en_o}, 4'b0000);
    check("postrst_fail", {fail_cnt_o, fail_addr_o}, 0);
    run_bist(1'b0, "rerun");
    check("rerun_pass", pass_o, 1);
    check("rerun_failcnt", fail_cnt_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
